v810_bus_initiator: RTL and testbench
=====================================

// Module: v810_bus_initiator
// PURPOSE
// Synthesizable V810 external-bus master for memory/peripheral benches and future DMA.
// - Takes single-word requests on a simple REQ/ACK port.
// - Drives them as V810 bus cycles on A/D_O/BEn/ST/DAn/MRQn/RW/BCYSTn, the same pins v810_mem drives.
// - Honours READYn wait states and SZRQn 16-bit bus sizing.
// - Lets ROM/RAM/resizer responders be exercised without the CPU core.
// PARAMETERS
// WAIT_MAX  16  T2 cycles without READYn=0 before abort with ERR; 0 = never time out
// PORTS
// CLK     in   1   clock
// RES     in   1   synchronous reset, active high
// CE      in   1   clock enable; all state advances only when CE=1
// REQ     in   1   request, sampled only in IDLE
// ADDR    in   32  byte address (ADDR[1:0] ignored on the bus, word aligned)
// WDATA   in   32  write data, lane-fixed by byte address
// BE      in   4   byte enables, active high, must be nonzero
// WR      in   1   1=write, 0=read
// MEMRQ   in   1   1=memory space (MRQn=0), 0=I/O space
// STIN    in   2   bus status code to drive on ST
// ACK     out  1   one-CE-cycle pulse: request finished
// ERR     out  1   valid with ACK: 1 = timed out
// RDATA   out  32  read data, valid with ACK (held until next ACK)
// A       out  32  bus address
// D_I     in   32  bus read data
// D_O     out  32  bus write data
// BEn     out  4   byte enables, active low
// ST      out  2   bus status
// DAn     out  1   data strobe, active low
// MRQn    out  1   memory request, active low
// RW      out  1   1=read, 0=write
// BCYSTn  out  1   bus-cycle start, active low
// READYn  in   1   cycle end, sampled at CE edges in T2
// SZRQn   in   1   16-bit bus request, sampled with READYn=0
// BEHAVIOUR
// - All outputs registered.
// - Reset/idle values: ACK=0, ERR=0, RDATA=0, A=0, D_O=0, BEn=4'hF, ST=0, DAn=1, MRQn=1, RW=1, BCYSTn=1.
// - States: IDLE -> T1 -> T2 (repeats per wait) -> [T1H -> T2H] -> IDLE.
// - IDLE: on REQ, latch request.
//   - Outputs for T1: A={ADDR[31:2],2'b00}, BEn=~BE, RW=~WR, MRQn=~MEMRQ, ST=STIN, D_O=WDATA, BCYSTn=0, DAn=1.
// - T1: exactly one cycle. Next: BCYSTn=1, DAn=0, wait counter cleared. Go to T2.
// - T2: at each CE edge sample READYn.
//   - READYn=1: counter++.
//     - If WAIT_MAX!=0 and counter reaches WAIT_MAX: abort. All bus outputs to idle, ACK=1, ERR=1, RDATA unchanged.
//   - READYn=0, no split: read latches RDATA lanes enabled by BE from D_I, others 0. ACK=1, ERR=0, bus outputs idle, go IDLE.
//   - Split: taken iff READYn=0 & SZRQn=0 & BE[1:0]!=0 & BE[3:2]!=0.
//     - Latch RDATA[15:0] (read).
//     - Drive T1H: A=base|32'h2, BEn={~BE[3:2],2'b11}, BCYSTn=0, DAn=1; RW/MRQn/ST/D_O unchanged.
// - T1H/T2H: identical to T1/T2; split never repeats.
//   - Completion latches RDATA[31:16] from D_I[31:16]. Byte lanes are fixed by address; no lane swap.
// - SZRQn ignored when READYn=1, and in T2 when the request touches only one halfword.
// - Latency, REQ edge to ACK-high cycle: 2 + waits enabled cycles (unsplit); 4 + waits (split).
// - ACK cycle is IDLE; a REQ present during ACK is accepted (back-to-back allowed).
// - Request inputs are don't-care outside IDLE.
// - Timeout counter: 16 bits, saturating, reset at every T1/T1H.
// - CE=0: state, counter and all outputs hold. An ACK pulse lasts one enabled cycle.
// - RES=1 in any state: next edge all outputs idle, state IDLE, no ACK. An in-flight request is discarded. RES overrides CE.
// TESTING
// 1. Read ADDR=0000_0010 BE=F, READYn=0 in first T2, SZRQn=1, D_I=DEADBEEF
//    -> one BCYSTn pulse, A=0000_0010, BEn=0, RW=1, ACK 2 cycles after REQ, RDATA=DEADBEEF, ERR=0.
// 2. Write ADDR=0000_0404 WDATA=CAFEF00D BE=4'b0110, READYn=1 for 2 T2 cycles then 0
//    -> RW=0, BEn=4'b1001, D_O=CAFEF00D through T2, ACK at cycle 4.
// 3. Read ADDR=FFF0_0000 BE=F, SZRQn=0; D_I[15:0]=1234, then D_I[31:16]=5678
//    -> second BCYSTn with A=FFF0_0002, BEn=4'b0011, RDATA=5678_1234 at cycle 4.
// 4. Read BE=4'b0011, SZRQn=0 -> no split, single BCYSTn, ACK at cycle 2, RDATA[31:16]=0.
// 5. WAIT_MAX=4, READYn held 1 -> ACK with ERR=1 after 4 T2 cycles; DAn=1, BEn=F on ACK cycle.
// 6. RES during T2 of a split read -> idle outputs next edge, no ACK.
//    Then, with CE toggling 1/0, a new request completes with correct RDATA and a single-enabled-cycle ACK.

Source files
------------

// File: rtl/v810_bus_initiator.sv
// V810 external-bus master: turns single-word REQ/ACK requests into
// bus cycles with READYn wait states, timeout and 16-bit bus splitting.
module v810_bus_initiator #(
    parameter int WAIT_MAX = 16
) (
    input  logic        i_clk,
    input  logic        i_res,
    input  logic        i_ce,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_be,
    input  logic        i_wr,
    input  logic        i_memrq,
    input  logic [1:0]  i_stin,
    output logic        o_ack,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic [31:0] o_a,
    input  logic [31:0] i_d_i,
    output logic [31:0] o_d_o,
    output logic [3:0]  o_ben,
    output logic [1:0]  o_st,
    output logic        o_dan,
    output logic        o_mrqn,
    output logic        o_rw,
    output logic        o_bcystn,
    input  logic        i_readyn,
    input  logic        i_szrqn
);

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T1H, S_T2H} state_t;

    localparam logic [15:0] LP_WMAX = 16'(WAIT_MAX);

    state_t      r_state, w_state;
    logic [15:0] r_cnt, w_cnt;
    logic [3:0]  r_be, w_be;
    logic        r_wr, w_wr;
    logic [15:0] r_lo, w_lo;
    logic        r_ack, w_ack;
    logic        r_err, w_err;
    logic [31:0] r_rdata, w_rdata;
    logic [31:0] r_a, w_a;
    logic [31:0] r_do, w_do;
    logic [3:0]  r_ben, w_ben;
    logic [1:0]  r_st, w_st;
    logic        r_dan, w_dan;
    logic        r_mrqn, w_mrqn;
    logic        r_rw, w_rw;
    logic        r_bcystn, w_bcystn;

    logic [15:0] w_cnt_inc;
    logic        w_abort;
    logic        w_split;
    logic        w_to_idle;
    logic [31:0] w_lanes;

    // Disabled byte lanes read back as zero
    function automatic logic [31:0] f_lanes(input logic [31:0] d,
                                            input logic [3:0]  be);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            v[8*i +: 8] = be[i] ? d[8*i +: 8] : 8'h00;
        end
        return v;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_be     <= '0;
            r_wr     <= 1'b0;
            r_lo     <= '0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_a      <= '0;
            r_do     <= '0;
            r_ben    <= 4'hF;
            r_st     <= 2'd0;
            r_dan    <= 1'b1;
            r_mrqn   <= 1'b1;
            r_rw     <= 1'b1;
            r_bcystn <= 1'b1;
        end else if (i_ce) begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_be     <= w_be;
            r_wr     <= w_wr;
            r_lo     <= w_lo;
            r_ack    <= w_ack;
            r_err    <= w_err;
            r_rdata  <= w_rdata;
            r_a      <= w_a;
            r_do     <= w_do;
            r_ben    <= w_ben;
            r_st     <= w_st;
            r_dan    <= w_dan;
            r_mrqn   <= w_mrqn;
            r_rw     <= w_rw;
            r_bcystn <= w_bcystn;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_be      = r_be;
        w_wr      = r_wr;
        w_lo      = r_lo;
        w_ack     = 1'b0;
        w_err     = 1'b0;
        w_rdata   = r_rdata;
        w_a       = r_a;
        w_do      = r_do;
        w_ben     = r_ben;
        w_st      = r_st;
        w_dan     = r_dan;
        w_mrqn    = r_mrqn;
        w_rw      = r_rw;
        w_bcystn  = r_bcystn;
        w_to_idle = 1'b0;
        w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
        w_abort   = (WAIT_MAX != 0) && (w_cnt_inc == LP_WMAX);
        w_split   = !i_szrqn && (|r_be[1:0]) && (|r_be[3:2]);
        w_lanes   = f_lanes(i_d_i, r_be);

        unique case (r_state)
            S_IDLE: begin
                if (i_req) begin
                    w_be     = i_be;
                    w_wr     = i_wr;
                    w_a      = i_addr & 32'hFFFF_FFFC;
                    w_ben    = ~i_be;
                    w_rw     = ~i_wr;
                    w_mrqn   = ~i_memrq;
                    w_st     = i_stin;
                    w_do     = i_wdata;
                    w_bcystn = 1'b0;
                    w_dan    = 1'b1;
                    w_state  = S_T1;
                end
            end
            S_T1, S_T1H: begin
                w_bcystn = 1'b1;
                w_dan    = 1'b0;
                w_cnt    = '0;
                w_state  = (r_state == S_T1) ? S_T2 : S_T2H;
            end
            S_T2, S_T2H: begin
                if (i_readyn) begin
                    w_cnt = w_cnt_inc;
                    if (w_abort) begin
                        w_ack     = 1'b1;
                        w_err     = 1'b1;
                        w_to_idle = 1'b1;
                    end
                end else if (r_state == S_T2 && w_split) begin
                    // Low halfword done; rerun the upper half at base+2
                    w_lo     = w_lanes[15:0];
                    w_a      = r_a | 32'h2;
                    w_ben    = {~r_be[3:2], 2'b11};
                    w_bcystn = 1'b0;
                    w_dan    = 1'b1;
                    w_state  = S_T1H;
                end else begin
                    if (!r_wr) begin
                        w_rdata = (r_state == S_T2) ? w_lanes
                                                    : {w_lanes[31:16], r_lo};
                    end
                    w_ack     = 1'b1;
                    w_to_idle = 1'b1;
                end
            end
            default: w_to_idle = 1'b1;
        endcase

        if (w_to_idle) begin
            w_state  = S_IDLE;
            w_a      = '0;
            w_do     = '0;
            w_ben    = 4'hF;
            w_st     = 2'd0;
            w_dan    = 1'b1;
            w_mrqn   = 1'b1;
            w_rw     = 1'b1;
            w_bcystn = 1'b1;
        end
    end

    assign o_ack    = r_ack;
    assign o_err    = r_err;
    assign o_rdata  = r_rdata;
    assign o_a      = r_a;
    assign o_d_o    = r_do;
    assign o_ben    = r_ben;
    assign o_st     = r_st;
    assign o_dan    = r_dan;
    assign o_mrqn   = r_mrqn;
    assign o_rw     = r_rw;
    assign o_bcystn = r_bcystn;

endmodule

// File: tb/tb_v810_bus_initiator.sv
// Directed bench for v810_bus_initiator: vector table plus reset and
// clock-enable sequences, with a simple READYn/SZRQn bus responder.
module tb_v810_bus_initiator;

    logic        clk = 1'b0;
    logic        res, ce, req, wr, memrq, readyn, szrqn;
    logic [31:0] addr, wdata, d_i;
    logic [3:0]  be;
    logic [1:0]  stin;
    logic        ack, err, dan, mrqn, rw, bcystn;
    logic [31:0] rdata, a, d_o;
    logic [3:0]  ben;
    logic [1:0]  st;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    v810_bus_initiator #(.WAIT_MAX(4)) dut (
        .i_clk(clk), .i_res(res), .i_ce(ce), .i_req(req),
        .i_addr(addr), .i_wdata(wdata), .i_be(be), .i_wr(wr),
        .i_memrq(memrq), .i_stin(stin), .o_ack(ack), .o_err(err),
        .o_rdata(rdata), .o_a(a), .i_d_i(d_i), .o_d_o(d_o),
        .o_ben(ben), .o_st(st), .o_dan(dan), .o_mrqn(mrqn),
        .o_rw(rw), .o_bcystn(bcystn), .i_readyn(readyn),
        .i_szrqn(szrqn)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        wr;
        logic        memrq;
        logic [1:0]  stin;
        int          waits;
        logic        szrqn;
        logic [31:0] dlo;
        logic [31:0] dhi;
        logic [31:0] e_a;
        logic [3:0]  e_ben;
        logic        e_rw;
        logic        e_mrqn;
        logic [1:0]  e_st;
        logic [31:0] e_rd;
        int          e_lat;
        logic        e_err;
        int          e_nbcy;
        logic [31:0] e_a2;
        logic [3:0]  e_ben2;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic do_txn(input int idx, input vec_t v);
        int          nb, w, lat;
        logic        done;
        logic [31:0] a1, a2, dot2;
        logic [3:0]  b1, b2;
        logic        rw1, mq1;
        logic [1:0]  st1;
        string       p;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        req = 1'b1; addr = v.addr; wdata = v.wdata; be = v.be;
        wr = v.wr; memrq = v.memrq; stin = v.stin;
        readyn = 1'b1; szrqn = 1'b1; d_i = '0;
        @(posedge clk);
        #1 req = 1'b0;
        nb = 0; w = 0; lat = -1; done = 1'b0;
        a1 = '0; a2 = '0; b1 = '0; b2 = '0; dot2 = '0;
        rw1 = 1'b0; mq1 = 1'b0; st1 = '0;
        for (int j = 0; j < 40 && !done; j++) begin
            @(negedge clk);
            if (!bcystn) begin
                nb++; w = 0;
                if (nb == 1) begin
                    a1 = a; b1 = ben; rw1 = rw; mq1 = mrqn; st1 = st;
                end else begin
                    a2 = a; b2 = ben;
                end
            end
            if (ack) begin
                done = 1'b1; lat = j;
                chk({p, "_err"}, 32'(err), 32'(v.e_err));
                chk({p, "_rdata"}, rdata, v.e_rd);
                chk({p, "_ackidle"}, {27'd0, ben, dan}, {27'd0, 4'hF, 1'b1});
            end else if (!dan) begin
                dot2 = d_o;
                if (w < v.waits) begin
                    readyn = 1'b1; w++;
                end else begin
                    readyn = 1'b0; szrqn = v.szrqn;
                    d_i = (nb >= 2) ? v.dhi : v.dlo;
                end
            end else begin
                readyn = 1'b1; szrqn = 1'b1;
            end
        end
        chk({p, "_lat"}, 32'(lat), 32'(v.e_lat));
        chk({p, "_nbcy"}, 32'(nb), 32'(v.e_nbcy));
        chk({p, "_a"}, a1, v.e_a);
        chk({p, "_ctl"}, {24'd0, b1, rw1, mq1, st1},
            {24'd0, v.e_ben, v.e_rw, v.e_mrqn, v.e_st});
        chk({p, "_dout"}, dot2, v.wdata);
        if (v.e_nbcy == 2) begin
            chk({p, "_a2"}, a2, v.e_a2);
            chk({p, "_ben2"}, 32'(b2), 32'(v.e_ben2));
        end
        @(negedge clk);
        chk({p, "_ackpulse"}, 32'(ack), 32'd0);
    endtask

    initial begin
        int nack;
        vecs[0] = '{32'h0000_0010, 32'h0, 4'hF, 1'b0, 1'b1, 2'd0, 0, 1'b1,
                    32'hDEAD_BEEF, 32'h0, 32'h0000_0010, 4'h0, 1'b1, 1'b0,
                    2'd0, 32'hDEAD_BEEF, 2, 1'b0, 1, 32'h0, 4'hF};
        vecs[1] = '{32'h0000_0404, 32'hCAFE_F00D, 4'b0110, 1'b1, 1'b0,
                    2'd2, 2, 1'b1, 32'h0, 32'h0, 32'h0000_0404, 4'b1001,
                    1'b0, 1'b1, 2'd2, 32'hDEAD_BEEF, 4, 1'b0, 1, 32'h0,
                    4'hF};
        vecs[2] = '{32'hFFF0_0000, 32'h0, 4'hF, 1'b0, 1'b1, 2'd1, 0, 1'b0,
                    32'hAAAA_1234, 32'h5678_BBBB, 32'hFFF0_0000, 4'h0,
                    1'b1, 1'b0, 2'd1, 32'h5678_1234, 4, 1'b0, 2,
                    32'hFFF0_0002, 4'b0011};
        vecs[3] = '{32'h0000_0020, 32'h0, 4'b0011, 1'b0, 1'b1, 2'd3, 0,
                    1'b0, 32'h1122_3344, 32'h0, 32'h0000_0020, 4'b1100,
                    1'b1, 1'b0, 2'd3, 32'h0000_3344, 2, 1'b0, 1, 32'h0,
                    4'hF};
        vecs[4] = '{32'h0000_0100, 32'h0, 4'hF, 1'b0, 1'b1, 2'd0, 99, 1'b1,
                    32'h0, 32'h0, 32'h0000_0100, 4'h0, 1'b1, 1'b0, 2'd0,
                    32'h0000_3344, 5, 1'b1, 1, 32'h0, 4'hF};
        vecs[5] = '{32'h0000_0203, 32'h0, 4'b0100, 1'b0, 1'b1, 2'd0, 1,
                    1'b1, 32'hA1B2_C3D4, 32'h0, 32'h0000_0200, 4'b1011,
                    1'b1, 1'b0, 2'd0, 32'h00B2_0000, 3, 1'b0, 1, 32'h0,
                    4'hF};
        vecs[6] = '{32'h0000_1000, 32'h0, 4'b1001, 1'b0, 1'b1, 2'd0, 1,
                    1'b0, 32'h0102_0304, 32'h0506_0708, 32'h0000_1000,
                    4'b0110, 1'b1, 1'b0, 2'd0, 32'h0500_0004, 6, 1'b0, 2,
                    32'h0000_1002, 4'b0111};
        vecs[7] = '{32'h0000_3000, 32'h1234_5678, 4'hF, 1'b1, 1'b1, 2'd0,
                    0, 1'b0, 32'h0, 32'h0, 32'h0000_3000, 4'h0, 1'b0, 1'b0,
                    2'd0, 32'h0500_0004, 4, 1'b0, 2, 32'h0000_3002,
                    4'b0011};

        res = 1'b1; ce = 1'b1; req = 1'b0; addr = '0; wdata = '0;
        be = 4'hF; wr = 1'b0; memrq = 1'b1; stin = '0;
        readyn = 1'b1; szrqn = 1'b1; d_i = '0;
        repeat (2) @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        chk("rst_ack_err", {30'd0, ack, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_a", a, 32'd0);
        chk("rst_dout", d_o, 32'd0);
        chk("rst_ctl", {23'd0, ben, st, dan, mrqn, rw},
            {23'd0, 4'hF, 2'd0, 1'b1, 1'b1, 1'b1});
        chk("rst_bcystn", 32'(bcystn), 32'd1);

        for (int i = 0; i < 8; i++) do_txn(i, vecs[i]);

        // Reset in T2 of a would-be split read
        @(negedge clk);
        req = 1'b1; addr = 32'h0000_0700; be = 4'hF; wr = 1'b0;
        readyn = 1'b1; szrqn = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("res_in_t2", 32'(dan), 32'd0);
        res = 1'b1; readyn = 1'b0; szrqn = 1'b0; d_i = 32'h1111_2222;
        @(negedge clk);
        res = 1'b0; readyn = 1'b1; szrqn = 1'b1;
        chk("res_idle", {26'd0, ben, dan, bcystn}, {26'd0, 4'hF, 2'b11});
        chk("res_a", a, 32'd0);
        chk("res_rdata", rdata, 32'd0);
        nack = 0;
        for (int j = 0; j < 6; j++) begin
            chk("res_noack", 32'(ack), 32'd0);
            @(negedge clk);
        end

        // Request under an alternating clock enable
        req = 1'b1; addr = 32'h0000_0500; be = 4'hF; wr = 1'b0;
        memrq = 1'b1; readyn = 1'b0; szrqn = 1'b1; d_i = 32'h0BAD_F00D;
        ce = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (ack) nack++;
            req = 1'b0;
            ce = ~ce;
        end
        ce = 1'b1;
        chk("ce_acklen", 32'(nack), 32'd2);
        chk("ce_rdata", rdata, 32'h0BAD_F00D);
        chk("ce_err", 32'(err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
